// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, synchronous clear, wrap/saturate
// mode, combinational terminal count and registered carry/borrow/load-error pulses.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Val,
  input  logic             Up_Dn,
  output logic [WIDTH-1:0] Count,
  output logic             Term,
  output logic             Carry,
  output logic             Borrow,
  output logic             Load_Err
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam bit               SAT = (SATURATE != 0);

  logic             at_max, at_min;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cy_nxt, bw_nxt, le_nxt;

  assign at_max = (Count == MAX);
  assign at_min = (Count == '0);
  assign Term   = Up_Dn ? at_max : at_min;

  // In saturate mode the pulses mark arrival at a limit, not residence there.
  always_comb begin
    cnt_nxt = Count;
    cy_nxt  = 1'b0;
    bw_nxt  = 1'b0;
    le_nxt  = 1'b0;
    if (Clear) begin
      cnt_nxt = '0;
    end else if (Load) begin
      if (Load_Val > MAX) begin
        cnt_nxt = MAX;
        le_nxt  = 1'b1;
      end else begin
        cnt_nxt = Load_Val;
      end
    end else if (En) begin
      if (Up_Dn) begin
        if (!at_max) begin
          cnt_nxt = Count + WIDTH'(1);
          cy_nxt  = SAT && (cnt_nxt == MAX);
        end else if (!SAT) begin
          cnt_nxt = '0;
          cy_nxt  = 1'b1;
        end
      end else begin
        if (!at_min) begin
          cnt_nxt = Count - WIDTH'(1);
          bw_nxt  = SAT && (Count == WIDTH'(1));
        end else if (!SAT) begin
          cnt_nxt = MAX;
          bw_nxt  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count    <= '0;
      Carry    <= 1'b0;
      Borrow   <= 1'b0;
      Load_Err <= 1'b0;
    end else begin
      Count    <= cnt_nxt;
      Carry    <= cy_nxt;
      Borrow   <= bw_nxt;
      Load_Err <= le_nxt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: wrap, saturate and power-of-two counters share controls;
// a two-stage decade cascade runs alongside on its own enable.
module tb_mod_updown_counter;

  typedef struct { int cnt; bit cy; bit bw; bit le; } st_t;
  typedef struct { st_t w; st_t s; st_t p; st_t u; st_t t; } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, en = 1'b0, ld = 1'b0, ud = 1'b1, cen = 1'b0;
  logic [3:0] ldv = '0;

  logic [3:0] w_cnt, s_cnt, u_cnt, t_cnt;
  logic [2:0] p_cnt;
  logic w_term, w_cy, w_bw, w_le;
  logic s_term, s_cy, s_bw, s_le;
  logic p_term, p_cy, p_bw, p_le;
  logic u_term, u_cy, u_bw, u_le;
  logic t_term, t_cy, t_bw, t_le;

  int   n_vec = 0, n_bad = 0;
  st_t  m_w, m_s, m_p, m_u, m_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap (
    .Clock(clk), .Reset(rst_n), .Clear(clr), .En(en), .Load(ld), .Load_Val(ldv),
    .Up_Dn(ud), .Count(w_cnt), .Term(w_term), .Carry(w_cy), .Borrow(w_bw), .Load_Err(w_le));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat (
    .Clock(clk), .Reset(rst_n), .Clear(clr), .En(en), .Load(ld), .Load_Val(ldv),
    .Up_Dn(ud), .Count(s_cnt), .Term(s_term), .Carry(s_cy), .Borrow(s_bw), .Load_Err(s_le));
  mod_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_pow (
    .Clock(clk), .Reset(rst_n), .Clear(clr), .En(en), .Load(ld), .Load_Val(ldv[2:0]),
    .Up_Dn(ud), .Count(p_cnt), .Term(p_term), .Carry(p_cy), .Borrow(p_bw), .Load_Err(p_le));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
    .Clock(clk), .Reset(rst_n), .Clear(1'b0), .En(cen), .Load(1'b0), .Load_Val(4'd0),
    .Up_Dn(1'b1), .Count(u_cnt), .Term(u_term), .Carry(u_cy), .Borrow(u_bw), .Load_Err(u_le));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
    .Clock(clk), .Reset(rst_n), .Clear(1'b0), .En(cen & u_term), .Load(1'b0), .Load_Val(4'd0),
    .Up_Dn(1'b1), .Count(t_cnt), .Term(t_term), .Carry(t_cy), .Borrow(t_bw), .Load_Err(t_le));

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_st(input string tag, input int cnt, input bit cy, input bit bw,
                        input bit le, input st_t e);
    chk({tag, ".cnt"}, cnt, e.cnt);
    chk({tag, ".carry"}, int'(cy), int'(e.cy));
    chk({tag, ".borrow"}, int'(bw), int'(e.bw));
    chk({tag, ".lerr"}, int'(le), int'(e.le));
  endtask

  function automatic st_t nxt(st_t s, int md, bit sat, bit c, bit l, int v, bit e, bit d);
    st_t r;
    r = '{s.cnt, 1'b0, 1'b0, 1'b0};
    if (c) r.cnt = 0;
    else if (l) begin
      if (v < md) r.cnt = v;
      else begin r.cnt = md - 1; r.le = 1'b1; end
    end else if (e && d) begin
      if (s.cnt < md - 1) begin r.cnt = s.cnt + 1; r.cy = sat && (r.cnt == md - 1); end
      else if (!sat) begin r.cnt = 0; r.cy = 1'b1; end
    end else if (e) begin
      if (s.cnt > 0) begin r.cnt = s.cnt - 1; r.bw = sat && (r.cnt == 0); end
      else if (!sat) begin r.cnt = md - 1; r.bw = 1'b1; end
    end
    return r;
  endfunction

  function automatic int term_of(st_t s, int md, bit d);
    return d ? int'(s.cnt == md - 1) : int'(s.cnt == 0);
  endfunction

  // Drive one cycle of controls, predict, then compare after the edge.
  task automatic step(input bit c, input bit e, input bit l, input int v, input bit d, input bit ce);
    exp_t x;
    bit   lo_t;
    clr = c; en = e; ld = l; ldv = 4'(v); ud = d; cen = ce;
    #1;
    chk("w.term", int'(w_term), term_of(m_w, 10, d));
    chk("s.term", int'(s_term), term_of(m_s, 10, d));
    chk("p.term", int'(p_term), term_of(m_p, 8, d));
    chk("lo.term", int'(u_term), term_of(m_u, 10, 1'b1));
    lo_t = (m_u.cnt == 9);
    m_w = nxt(m_w, 10, 1'b0, c, l, v, e, d);
    m_s = nxt(m_s, 10, 1'b1, c, l, v, e, d);
    m_p = nxt(m_p, 8, 1'b0, c, l, v & 7, e, d);
    m_u = nxt(m_u, 10, 1'b0, 1'b0, 1'b0, 0, ce, 1'b1);
    m_t = nxt(m_t, 10, 1'b0, 1'b0, 1'b0, 0, ce && lo_t, 1'b1);
    sb.push_back('{m_w, m_s, m_p, m_u, m_t});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk_st("wrap", int'(w_cnt), w_cy, w_bw, w_le, x.w);
    chk_st("sat", int'(s_cnt), s_cy, s_bw, s_le, x.s);
    chk_st("pow2", int'(p_cnt), p_cy, p_bw, p_le, x.p);
    chk_st("units", int'(u_cnt), u_cy, u_bw, u_le, x.u);
    chk_st("tens", int'(t_cnt), t_cy, t_bw, t_le, x.t);
  endtask

  task automatic zero_models();
    m_w = '{0, 1'b0, 1'b0, 1'b0};
    m_s = m_w; m_p = m_w; m_u = m_w; m_t = m_w;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".w"}, int'({w_cnt, w_cy, w_bw, w_le}), 0);
    chk({tag, ".s"}, int'({s_cnt, s_cy, s_bw, s_le}), 0);
    chk({tag, ".p"}, int'({p_cnt, p_cy, p_bw, p_le}), 0);
    chk({tag, ".u"}, int'({u_cnt, u_cy, u_bw, u_le}), 0);
    chk({tag, ".t"}, int'({t_cnt, t_cy, t_bw, t_le}), 0);
  endtask

  initial begin
    zero_models();
    #2;
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    // count up through the wrap
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1, 0);
    // load then count down through the floor
    step(0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    // out-of-range load, pulse clears, then clear beats load and enable
    step(0, 1, 1, 13, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 5, 1, 0);
    // saturation limits
    step(0, 0, 1, 7, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    // asynchronous reset between edges
    step(0, 0, 1, 6, 1, 0);
    rst_n = 1'b0;
    #2;
    zero_models();
    chk_reset("async_rst");
    rst_n = 1'b1;
    step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, i[0], 0);
    // decade cascade 00..99 and back to 00
    for (int i = 0; i < 102; i++) step(0, 0, 0, 0, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
